// File: rtl/mem_access_ctrl.sv
// ============================================================================
// Module  : mem_access_ctrl
// Brief   : MEM-stage load/store sequencer with req/ack data-memory handshake.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_access_ctrl #(
    parameter int ADDR_BIT = 10,
    parameter int MAX_WAIT = 15
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                mem_re_in,
    input  logic                mem_we_in,
    input  logic [1:0]          mem_size_in,
    input  logic                mem_sign_in,
    input  logic [31:0]         addr_in,
    input  logic [31:0]         wdata_in,
    output logic                dm_req,
    output logic                dm_we,
    output logic [ADDR_BIT-1:0] dm_addr,
    output logic [31:0]         dm_wdata,
    output logic [3:0]          dm_byte_en,
    input  logic                dm_ack,
    input  logic [31:0]         dm_rdata,
    output logic                stall,
    output logic [31:0]         datamem_data,
    output logic                misalign,
    output logic                timeout
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [7:0] c_wait_last = 8'(MAX_WAIT - 1);

    state_t              state_q;
    logic [7:0]          wait_cnt_q;
    logic                we_q;
    logic                sign_q;
    logic [1:0]          size_q;
    logic [1:0]          lane_q;
    logic                dm_req_q;
    logic                dm_we_q;
    logic [ADDR_BIT-1:0] dm_addr_q;
    logic [31:0]         dm_wdata_q;
    logic [3:0]          dm_byte_en_q;
    logic [31:0]         datamem_data_q;
    logic                misalign_q;
    logic                timeout_q;

    logic                w_access;
    logic [1:0]          w_lane;
    logic                w_misaligned;
    logic                w_start;
    logic                w_err;
    logic [31:0]         w_wdata;
    logic [3:0]          w_byte_en;
    logic [7:0]          w_ld_byte;
    logic [15:0]         w_ld_half;
    logic [31:0]         w_load_data;
    logic [31-ADDR_BIT-2:0] w_unused_addr;

    assign w_access      = mem_we_in | mem_re_in;
    assign w_lane        = addr_in[1:0];
    assign w_unused_addr = addr_in[31:ADDR_BIT+2];

    // Size 2'b11 is handled as a word, so it shares the word alignment rule.
    assign w_misaligned = ((mem_size_in == 2'b01) && w_lane[0]) ||
                          (mem_size_in[1] && (w_lane != 2'b00));
    assign w_start      = w_access && !w_misaligned;
    assign w_err        = w_access && w_misaligned;

    always_comb begin
        w_wdata   = wdata_in;
        w_byte_en = 4'b1111;
        case (mem_size_in)
            2'b00: begin
                w_wdata   = {4{wdata_in[7:0]}};
                w_byte_en = 4'b0001 << w_lane;
            end
            2'b01: begin
                w_wdata   = {2{wdata_in[15:0]}};
                w_byte_en = w_lane[1] ? 4'b1100 : 4'b0011;
            end
            default: begin
                w_wdata   = wdata_in;
                w_byte_en = 4'b1111;
            end
        endcase
    end

    always_comb begin
        w_ld_byte = 8'h00;
        case (lane_q)
            2'd0:    w_ld_byte = dm_rdata[7:0];
            2'd1:    w_ld_byte = dm_rdata[15:8];
            2'd2:    w_ld_byte = dm_rdata[23:16];
            default: w_ld_byte = dm_rdata[31:24];
        endcase
        w_ld_half   = lane_q[1] ? dm_rdata[31:16] : dm_rdata[15:0];
        w_load_data = dm_rdata;
        case (size_q)
            2'b00:   w_load_data = {{24{sign_q & w_ld_byte[7]}}, w_ld_byte};
            2'b01:   w_load_data = {{16{sign_q & w_ld_half[15]}}, w_ld_half};
            default: w_load_data = dm_rdata;
        endcase
    end

    // The IDLE term lets the pipeline freeze in the same cycle the request is seen.
    assign stall = !rst && (((state_q == S_IDLE) && w_start) || (state_q == S_BUSY));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= S_IDLE;
            wait_cnt_q     <= 8'd0;
            we_q           <= 1'b0;
            sign_q         <= 1'b0;
            size_q         <= 2'b00;
            lane_q         <= 2'b00;
            dm_req_q       <= 1'b0;
            dm_we_q        <= 1'b0;
            dm_addr_q      <= '0;
            dm_wdata_q     <= 32'd0;
            dm_byte_en_q   <= 4'b0000;
            datamem_data_q <= 32'd0;
            misalign_q     <= 1'b0;
            timeout_q      <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (w_start) begin
                        we_q         <= mem_we_in;
                        sign_q       <= mem_sign_in;
                        size_q       <= mem_size_in;
                        lane_q       <= w_lane;
                        dm_req_q     <= 1'b1;
                        dm_we_q      <= mem_we_in;
                        dm_addr_q    <= addr_in[ADDR_BIT+1:2];
                        dm_wdata_q   <= w_wdata;
                        dm_byte_en_q <= mem_we_in ? w_byte_en : 4'b0000;
                        wait_cnt_q   <= 8'd0;
                        state_q      <= S_BUSY;
                    end else if (w_err) begin
                        misalign_q     <= 1'b1;
                        datamem_data_q <= 32'd0;
                    end
                end
                S_BUSY: begin
                    if (dm_ack) begin
                        dm_req_q       <= 1'b0;
                        datamem_data_q <= we_q ? 32'd0 : w_load_data;
                        state_q        <= S_DONE;
                    end else if (wait_cnt_q == c_wait_last) begin
                        dm_req_q       <= 1'b0;
                        timeout_q      <= 1'b1;
                        datamem_data_q <= 32'd0;
                        state_q        <= S_DONE;
                    end else begin
                        wait_cnt_q <= wait_cnt_q + 8'd1;
                    end
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    assign dm_req       = dm_req_q;
    assign dm_we        = dm_we_q;
    assign dm_addr      = dm_addr_q;
    assign dm_wdata     = dm_wdata_q;
    assign dm_byte_en   = dm_byte_en_q;
    assign datamem_data = datamem_data_q;
    assign misalign     = misalign_q;
    assign timeout      = timeout_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_access_ctrl.sv
// ============================================================================
// Module  : tb_mem_access_ctrl
// Brief   : Scoreboard bench for mem_access_ctrl using directed vectors.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_mem_access_ctrl;

    localparam int AB = 10;
    localparam int MW = 5;

    logic          clk = 1'b0;
    logic          rst;
    logic          mem_re_in, mem_we_in, mem_sign_in;
    logic [1:0]    mem_size_in;
    logic [31:0]   addr_in, wdata_in;
    logic          dm_req, dm_we, dm_ack;
    logic [AB-1:0] dm_addr;
    logic [31:0]   dm_wdata, dm_rdata, datamem_data;
    logic [3:0]    dm_byte_en;
    logic          stall, misalign, timeout;

    always #5 clk = ~clk;

    mem_access_ctrl #(.ADDR_BIT(AB), .MAX_WAIT(MW)) dut (
        .clk(clk), .rst(rst),
        .mem_re_in(mem_re_in), .mem_we_in(mem_we_in),
        .mem_size_in(mem_size_in), .mem_sign_in(mem_sign_in),
        .addr_in(addr_in), .wdata_in(wdata_in),
        .dm_req(dm_req), .dm_we(dm_we), .dm_addr(dm_addr),
        .dm_wdata(dm_wdata), .dm_byte_en(dm_byte_en),
        .dm_ack(dm_ack), .dm_rdata(dm_rdata),
        .stall(stall), .datamem_data(datamem_data),
        .misalign(misalign), .timeout(timeout)
    );

    typedef struct {
        logic          we;
        logic [AB-1:0] addr;
        logic [31:0]   wdata;
        logic [3:0]    be;
        logic          chk_wdata;
    } req_t;

    typedef struct {
        logic [31:0] data;
        int          stalls;
        logic        tmo;
    } rsp_t;

    req_t req_q[$];
    rsp_t rsp_q[$];
    int   n_chk  = 0;
    int   n_fail = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    task automatic push(input logic we, input logic [AB-1:0] a, input logic [31:0] wd,
                        input logic [3:0] be, input logic cw, input logic [31:0] d,
                        input int st, input logic tmo);
        req_t r;
        rsp_t s;
        r.we = we; r.addr = a; r.wdata = wd; r.be = be; r.chk_wdata = cw;
        s.data = d; s.stalls = st; s.tmo = tmo;
        req_q.push_back(r);
        rsp_q.push_back(s);
    endtask

    // Drives one request; acks in BUSY cycle ack_cyc (0 = never ack).
    task automatic access(input logic we, input logic re, input logic [1:0] sz,
                          input logic sg, input logic [31:0] a, input logic [31:0] wd,
                          input int ack_cyc, input logic [31:0] rd);
        int n;
        @(posedge clk); #1;
        mem_we_in = we; mem_re_in = re; mem_size_in = sz;
        mem_sign_in = sg; addr_in = a; wdata_in = wd;
        @(posedge clk); #1;
        n = 1;
        while (stall && n <= 40) begin
            dm_ack   = (n == ack_cyc);
            dm_rdata = (n == ack_cyc) ? rd : 32'h5A5A_5A5A;
            @(posedge clk); #1;
            n++;
        end
        if (n > 40) chk("busy_bound", 32'(n), 32'd40);
        dm_ack = 1'b0; mem_we_in = 1'b0; mem_re_in = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    // Monitor: request fields on dm_req rise, results when stall falls.
    initial begin
        logic prev_req;
        int   scnt;
        req_t r;
        rsp_t s;
        prev_req = 1'b0;
        scnt = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                scnt = 0;
            end else begin
                if (dm_req && !prev_req) begin
                    if (req_q.size() == 0) begin
                        chk("req_unexpected", 32'd1, 32'd0);
                    end else begin
                        r = req_q.pop_front();
                        chk("req_we", dm_we, r.we);
                        chk("req_addr", dm_addr, r.addr);
                        chk("req_byte_en", dm_byte_en, r.be);
                        if (r.chk_wdata) chk("req_wdata", dm_wdata, r.wdata);
                    end
                end
                if (stall) begin
                    scnt++;
                end else if (scnt > 0) begin
                    if (rsp_q.size() == 0) begin
                        chk("rsp_unexpected", 32'd1, 32'd0);
                    end else begin
                        s = rsp_q.pop_front();
                        chk("rsp_data", datamem_data, s.data);
                        chk("rsp_stall_cycles", 32'(scnt), 32'(s.stalls));
                        chk("rsp_timeout", timeout, s.tmo);
                    end
                    scnt = 0;
                end
            end
            prev_req = dm_req;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; mem_re_in = 1'b0; mem_we_in = 1'b0; mem_size_in = 2'b00;
        mem_sign_in = 1'b0; addr_in = 32'd0; wdata_in = 32'd0;
        dm_ack = 1'b0; dm_rdata = 32'd0;
        repeat (2) @(posedge clk);
        #1;
        mem_re_in = 1'b1; mem_size_in = 2'b10; addr_in = 32'h10;
        #1;
        chk("rst_stall_forced", stall, 1'b0);
        chk("rst_dm_req", dm_req, 1'b0);
        chk("rst_data", datamem_data, 32'd0);
        chk("rst_flags", {misalign, timeout, dm_we}, 3'b000);
        chk("rst_byte_en", dm_byte_en, 4'b0000);
        mem_re_in = 1'b0;
        rst = 1'b0;

        push(1'b0, 10'd4,    32'd0,        4'b0000, 1'b0, 32'hDEAD_BEEF, 4, 1'b0);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h10, 32'd0, 3, 32'hDEAD_BEEF);
        push(1'b0, 10'd4,    32'd0,        4'b0000, 1'b0, 32'hFFFF_FF80, 2, 1'b0);
        access(1'b0, 1'b1, 2'b00, 1'b1, 32'h13, 32'd0, 1, 32'h8012_3456);
        push(1'b0, 10'd4,    32'd0,        4'b0000, 1'b0, 32'h0000_0080, 2, 1'b0);
        access(1'b0, 1'b1, 2'b00, 1'b0, 32'h13, 32'd0, 1, 32'h8012_3456);
        push(1'b1, 10'd8,    32'hABCD_ABCD, 4'b1100, 1'b1, 32'd0, 3, 1'b0);
        access(1'b1, 1'b0, 2'b01, 1'b0, 32'h22, 32'h1234_ABCD, 2, 32'hFFFF_FFFF);
        push(1'b1, 10'd13,   32'hA5A5_A5A5, 4'b0010, 1'b1, 32'd0, 2, 1'b0);
        access(1'b1, 1'b0, 2'b00, 1'b0, 32'h35, 32'h0000_00A5, 1, 32'd0);
        push(1'b0, 10'd64,   32'd0,        4'b0000, 1'b0, 32'hFFFF_8001, 2, 1'b0);
        access(1'b0, 1'b1, 2'b01, 1'b1, 32'h102, 32'd0, 1, 32'h8001_7FFF);
        push(1'b0, 10'd64,   32'd0,        4'b0000, 1'b0, 32'h0000_7FFF, 2, 1'b0);
        access(1'b0, 1'b1, 2'b01, 1'b1, 32'h100, 32'd0, 1, 32'h8001_7FFF);
        push(1'b1, 10'd1023, 32'hCAFE_F00D, 4'b1111, 1'b1, 32'd0, 2, 1'b0);
        access(1'b1, 1'b1, 2'b11, 1'b0, 32'hFFC, 32'hCAFE_F00D, 1, 32'h1111_1111);

        // Misaligned word load, then misaligned half store.
        @(posedge clk); #1;
        mem_re_in = 1'b1; mem_size_in = 2'b10; addr_in = 32'h6;
        #1;
        chk("misalign_stall", stall, 1'b0);
        @(posedge clk); #1;
        mem_re_in = 1'b0;
        chk("misalign_no_req", dm_req, 1'b0);
        chk("misalign_flag", misalign, 1'b1);
        chk("misalign_data", datamem_data, 32'd0);
        mem_we_in = 1'b1; mem_size_in = 2'b01; addr_in = 32'h1;
        #1;
        chk("misalign_half_stall", stall, 1'b0);
        @(posedge clk); #1;
        mem_we_in = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("misalign_sticky", misalign, 1'b1);
        chk("misalign_half_no_req", dm_req, 1'b0);
        do_reset();
        #1;
        chk("misalign_cleared", misalign, 1'b0);

        // Load data, then a timeout must zero it.
        push(1'b0, 10'd2,  32'd0, 4'b0000, 1'b0, 32'h1122_3344, 2, 1'b0);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h8, 32'd0, 1, 32'h1122_3344);
        push(1'b0, 10'd16, 32'd0, 4'b0000, 1'b0, 32'd0, MW + 1, 1'b1);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h40, 32'd0, 0, 32'd0);
        #1;
        chk("timeout_req_low", dm_req, 1'b0);
        repeat (2) @(posedge clk);
        #1;
        chk("timeout_sticky", timeout, 1'b1);

        push(1'b0, 10'd0, 32'd0, 4'b0000, 1'b0, 32'h0BAD_CAFE, 2, 1'b1);
        access(1'b0, 1'b1, 2'b10, 1'b0, 32'h0, 32'd0, 1, 32'h0BAD_CAFE);

        // Reset while BUSY; the later ack must be ignored.
        req_q.push_back('{we: 1'b0, addr: 10'd5, wdata: 32'd0, be: 4'b0000, chk_wdata: 1'b0});
        @(posedge clk); #1;
        mem_re_in = 1'b1; mem_size_in = 2'b10; addr_in = 32'h14;
        repeat (2) @(posedge clk);
        #1;
        chk("midrst_busy_stall", stall, 1'b1);
        rst = 1'b1; mem_re_in = 1'b0;
        #1;
        chk("midrst_stall_forced", stall, 1'b0);
        @(posedge clk); #1;
        chk("midrst_dm_req", dm_req, 1'b0);
        chk("midrst_data", datamem_data, 32'd0);
        chk("midrst_flags", {misalign, timeout, dm_we}, 3'b000);
        rst = 1'b0;
        dm_ack = 1'b1; dm_rdata = 32'h7777_7777;
        #1;
        chk("midrst_ack_stall", stall, 1'b0);
        @(posedge clk); #1;
        dm_ack = 1'b0;
        chk("late_ack_req", dm_req, 1'b0);
        chk("late_ack_data", datamem_data, 32'd0);
        chk("late_ack_stall", stall, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("req_queue_empty", 32'(req_q.size()), 32'd0);
        chk("rsp_queue_empty", 32'(rsp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule

`default_nettype wire
